// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler
//   Buffers up to DEPTH 16-bin FFT frames and hands them one at a time to the
//   peak-frequency analyzer using a start (ana_valid) / done (ana_done)
//   handshake. Each frame's dominant-bin index is returned on freq_out with a
//   one-cycle freq_valid pulse. Dropped frames and analyzer timeouts are
//   reported through sticky flags and a saturating drop counter.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   fft_valid         : one-cycle strobe, fft_d0..fft_d15 carry a frame
//   fft_d0..fft_d15   : bin data {real[31:16], imag[15:0]}
//   ana_valid         : one-cycle start pulse to the analyzer
//   ana_d0..ana_d15   : head-of-buffer frame (meaningful while ana_valid=1)
//   ana_done          : analyzer completion pulse, ana_freq valid with it
//   ana_freq          : analyzer result
//   freq_out          : last captured result (registered)
//   freq_valid        : one-cycle pulse when freq_out updates
//   busy              : FSM not idle or buffer non-empty
//   overflow, timeout : sticky status flags
//   drop_cnt          : dropped-frame count, saturating at 255
//   flag_clr          : synchronous clear of overflow, timeout and drop_cnt
module fft_frame_scheduler #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,  fft_d1,  fft_d2,  fft_d3,
  input  logic [31:0] fft_d4,  fft_d5,  fft_d6,  fft_d7,
  input  logic [31:0] fft_d8,  fft_d9,  fft_d10, fft_d11,
  input  logic [31:0] fft_d12, fft_d13, fft_d14, fft_d15,
  output logic        ana_valid,
  output logic [31:0] ana_d0,  ana_d1,  ana_d2,  ana_d3,
  output logic [31:0] ana_d4,  ana_d5,  ana_d6,  ana_d7,
  output logic [31:0] ana_d8,  ana_d9,  ana_d10, ana_d11,
  output logic [31:0] ana_d12, ana_d13, ana_d14, ana_d15,
  input  logic        ana_done,
  input  logic [3:0]  ana_freq,
  output logic [3:0]  freq_out,
  output logic        freq_valid,
  output logic        busy,
  output logic        overflow,
  output logic        timeout,
  output logic [7:0]  drop_cnt,
  input  logic        flag_clr
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [DEPTH][16];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    freq_q, freq_d;
  logic          fv_q, fv_d;
  logic          ovf_q, ovf_d;
  logic          to_q, to_d;
  logic [7:0]    drop_q, drop_d;
  logic          pop, push, drop, expire;

  logic [31:0] fft_d [16];
  logic [31:0] head  [16];

  assign fft_d[0]  = fft_d0;  assign fft_d[1]  = fft_d1;
  assign fft_d[2]  = fft_d2;  assign fft_d[3]  = fft_d3;
  assign fft_d[4]  = fft_d4;  assign fft_d[5]  = fft_d5;
  assign fft_d[6]  = fft_d6;  assign fft_d[7]  = fft_d7;
  assign fft_d[8]  = fft_d8;  assign fft_d[9]  = fft_d9;
  assign fft_d[10] = fft_d10; assign fft_d[11] = fft_d11;
  assign fft_d[12] = fft_d12; assign fft_d[13] = fft_d13;
  assign fft_d[14] = fft_d14; assign fft_d[15] = fft_d15;

  always_comb begin
    for (int unsigned b = 0; b < 16; b++) head[b] = mem_q[rd_ptr_q][b];
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    freq_d  = freq_q;
    fv_d    = 1'b0;
    pop     = 1'b0;
    expire  = 1'b0;
    unique case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_ISSUE;
      S_ISSUE: begin
        pop     = 1'b1;
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (ana_done) begin
          freq_d  = ana_freq;
          fv_d    = 1'b1;
          state_d = S_IDLE;
        end else if (timer_q == T_LAST) begin
          expire  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A full buffer still accepts a frame when the head leaves this cycle;
    // the new frame lands in the slot being vacated.
    push     = fft_valid && ((count_q != FULL) || pop);
    drop     = fft_valid && !push;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Events coinciding with flag_clr win over the clear.
    ovf_d = drop   || (ovf_q && !flag_clr);
    to_d  = expire || (to_q  && !flag_clr);
    if (flag_clr)                    drop_d = drop ? 8'd1 : 8'd0;
    else if (drop && drop_q != '1)   drop_d = drop_q + 8'd1;
    else                             drop_d = drop_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      freq_q   <= '0;
      fv_q     <= 1'b0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
      drop_q   <= '0;
      for (int unsigned e = 0; e < DEPTH; e++)
        for (int unsigned b = 0; b < 16; b++) mem_q[e][b] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      freq_q   <= freq_d;
      fv_q     <= fv_d;
      ovf_q    <= ovf_d;
      to_q     <= to_d;
      drop_q   <= drop_d;
      if (push)
        for (int unsigned b = 0; b < 16; b++) mem_q[wr_ptr_q][b] <= fft_d[b];
    end
  end

  assign ana_valid  = (state_q == S_ISSUE);
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign freq_out   = freq_q;
  assign freq_valid = fv_q;
  assign overflow   = ovf_q;
  assign timeout    = to_q;
  assign drop_cnt   = drop_q;

  assign ana_d0  = head[0];  assign ana_d1  = head[1];
  assign ana_d2  = head[2];  assign ana_d3  = head[3];
  assign ana_d4  = head[4];  assign ana_d5  = head[5];
  assign ana_d6  = head[6];  assign ana_d7  = head[7];
  assign ana_d8  = head[8];  assign ana_d9  = head[9];
  assign ana_d10 = head[10]; assign ana_d11 = head[11];
  assign ana_d12 = head[12]; assign ana_d13 = head[13];
  assign ana_d14 = head[14]; assign ana_d15 = head[15];

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Testbench for fft_frame_scheduler (DEPTH=2, TIMEOUT=31).
// Stimulus pushes expected analyzer results into exp_q; a monitor pops and
// compares on every freq_valid pulse. An analyzer model answers ana_valid
// according to a job queue and checks the issued frame's bin 3.
module tb_fft_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst, fft_valid, ana_done, flag_clr;
  logic [3:0]  ana_freq;
  logic [31:0] fd [16];
  logic [31:0] ad [16];
  logic        ana_valid, freq_valid, busy, overflow, timeout;
  logic [3:0]  freq_out;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  fft_frame_scheduler #(.DEPTH(2), .TIMEOUT(31)) dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(fd[0]),   .fft_d1(fd[1]),   .fft_d2(fd[2]),   .fft_d3(fd[3]),
    .fft_d4(fd[4]),   .fft_d5(fd[5]),   .fft_d6(fd[6]),   .fft_d7(fd[7]),
    .fft_d8(fd[8]),   .fft_d9(fd[9]),   .fft_d10(fd[10]), .fft_d11(fd[11]),
    .fft_d12(fd[12]), .fft_d13(fd[13]), .fft_d14(fd[14]), .fft_d15(fd[15]),
    .ana_valid(ana_valid),
    .ana_d0(ad[0]),   .ana_d1(ad[1]),   .ana_d2(ad[2]),   .ana_d3(ad[3]),
    .ana_d4(ad[4]),   .ana_d5(ad[5]),   .ana_d6(ad[6]),   .ana_d7(ad[7]),
    .ana_d8(ad[8]),   .ana_d9(ad[9]),   .ana_d10(ad[10]), .ana_d11(ad[11]),
    .ana_d12(ad[12]), .ana_d13(ad[13]), .ana_d14(ad[14]), .ana_d15(ad[15]),
    .ana_done(ana_done), .ana_freq(ana_freq),
    .freq_out(freq_out), .freq_valid(freq_valid), .busy(busy),
    .overflow(overflow), .timeout(timeout), .drop_cnt(drop_cnt),
    .flag_clr(flag_clr)
  );

  typedef struct {
    int          delay;
    logic [3:0]  freq;
    bit          respond;
    logic [31:0] d3;
  } job_t;

  int         checks = 0;
  int         failures = 0;
  int         fv_count = 0;
  int         spur_cnt = 0;
  int         spur_seen = 0;
  logic [3:0] spur_freq = 4'd0;
  job_t       jobs [$];
  logic [3:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic load_frame(input logic [31:0] d3, input logic [7:0] tag);
    for (int b = 0; b < 16; b++) fd[b] = {tag, 8'(b), tag, 8'(b)};
    fd[3] = d3;
  endtask

  task automatic send_cycle(input logic [31:0] d3, input logic [7:0] tag);
    load_frame(d3, tag);
    fft_valid = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  // Analyzer model
  initial begin
    job_t j;
    ana_done = 1'b0;
    ana_freq = 4'd0;
    forever begin
      tick();
      if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        ana_done  = 1'b1;
        ana_freq  = spur_freq;
        tick();
        ana_done  = 1'b0;
      end else if (ana_valid) begin
        if (jobs.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_issue actual=ana_valid required=no_issue");
        end else begin
          j = jobs.pop_front();
          chk("issue_d3", ad[3], j.d3);
          if (j.respond) begin
            repeat (j.delay) tick();
            ana_done = 1'b1;
            ana_freq = j.freq;
            tick();
            ana_done = 1'b0;
          end
        end
      end
    end
  end

  // Result monitor
  initial begin
    forever begin
      tick();
      if (freq_valid) begin
        fv_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_freq_valid actual=%0d required=none", freq_out);
        end else begin
          chk("freq_out", {28'd0, freq_out}, {28'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int fv0;
    rst = 1'b1;
    fft_valid = 1'b0;
    flag_clr = 1'b0;
    for (int b = 0; b < 16; b++) fd[b] = '0;
    repeat (3) tick();
    chk("rst_ana_valid", {31'd0, ana_valid}, 32'd0);
    chk("rst_freq_out",  {28'd0, freq_out}, 32'd0);
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    chk("rst_flags",     {30'd0, overflow, timeout}, 32'd0);
    chk("rst_drop_cnt",  {24'd0, drop_cnt}, 32'd0);
    chk("rst_ana_d3",    ad[3], 32'd0);
    rst = 1'b0;
    tick();

    // Single frame, result 5 after 14 cycles
    jobs.push_back('{14, 4'd5, 1'b1, 32'h0040_FFC0});
    exp_q.push_back(4'd5);
    send_cycle(32'h0040_FFC0, 8'h11);
    fft_valid = 1'b0;
    chk("t1_av_not_yet", {31'd0, ana_valid}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_av", {31'd0, ana_valid}, 32'd1);
    chk("t1_d3", ad[3], 32'h0040_FFC0);
    chk("t1_d0", ad[0], 32'h1100_1100);
    tick();
    chk("t1_av_one_cycle", {31'd0, ana_valid}, 32'd0);
    wait_idle("t1_idle", 60);
    chk("t1_overflow", {31'd0, overflow}, 32'd0);
    chk("t1_freq_hold", {28'd0, freq_out}, 32'd5);

    // Three back-to-back frames, all accepted
    jobs.push_back('{5, 4'd2,  1'b1, 32'hA000_0001});
    jobs.push_back('{5, 4'd7,  1'b1, 32'hA000_0002});
    jobs.push_back('{5, 4'd15, 1'b1, 32'hA000_0003});
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd7);
    exp_q.push_back(4'd15);
    send_cycle(32'hA000_0001, 8'h21);
    send_cycle(32'hA000_0002, 8'h22);
    send_cycle(32'hA000_0003, 8'h23);
    fft_valid = 1'b0;
    wait_idle("t2_idle", 100);
    chk("t2_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    chk("t2_overflow", {31'd0, overflow}, 32'd0);

    // Fourth frame during WAIT with a full buffer is dropped
    jobs.push_back('{6, 4'd3,  1'b1, 32'hB000_0001});
    jobs.push_back('{6, 4'd9,  1'b1, 32'hB000_0002});
    jobs.push_back('{6, 4'd12, 1'b1, 32'hB000_0003});
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd9);
    exp_q.push_back(4'd12);
    send_cycle(32'hB000_0001, 8'h31);
    send_cycle(32'hB000_0002, 8'h32);
    send_cycle(32'hB000_0003, 8'h33);
    send_cycle(32'hB000_0004, 8'h34);
    chk("t3_overflow", {31'd0, overflow}, 32'd1);
    chk("t3_drop_cnt", {24'd0, drop_cnt}, 32'd1);
    flag_clr = 1'b1;
    send_cycle(32'hB000_0005, 8'h35);
    fft_valid = 1'b0;
    chk("t3_clr_drop_overflow", {31'd0, overflow}, 32'd1);
    chk("t3_clr_drop_cnt", {24'd0, drop_cnt}, 32'd1);
    tick();
    flag_clr = 1'b0;
    chk("t3_cleared_overflow", {31'd0, overflow}, 32'd0);
    chk("t3_cleared_cnt", {24'd0, drop_cnt}, 32'd0);
    wait_idle("t3_idle", 100);

    // Analyzer never answers the first frame
    jobs.push_back('{0, 4'd0,  1'b0, 32'hC000_0001});
    jobs.push_back('{4, 4'd11, 1'b1, 32'hC000_0002});
    exp_q.push_back(4'd11);
    send_cycle(32'hC000_0001, 8'h41);
    send_cycle(32'hC000_0002, 8'h42);
    fft_valid = 1'b0;
    chk("t4_issue", {31'd0, ana_valid}, 32'd1);
    tick();
    n = 0;
    while (!timeout && n < 40) begin
      tick();
      n++;
    end
    chk("t4_timeout_cycles", n, 32'd31);
    chk("t4_av_idle", {31'd0, ana_valid}, 32'd0);
    tick();
    chk("t4_next_issue", {31'd0, ana_valid}, 32'd1);
    chk("t4_next_d3", ad[3], 32'hC000_0002);
    wait_idle("t4_idle", 60);
    chk("t4_timeout_sticky", {31'd0, timeout}, 32'd1);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    chk("t4_timeout_clr", {31'd0, timeout}, 32'd0);

    // Reset during WAIT with one frame still buffered
    jobs.push_back('{10, 4'd4, 1'b1, 32'hD000_0001});
    send_cycle(32'hD000_0001, 8'h51);
    send_cycle(32'hD000_0002, 8'h52);
    fft_valid = 1'b0;
    tick();
    tick();
    chk("t5_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_outputs", {24'd0, drop_cnt, ana_valid, freq_valid, overflow, timeout, freq_out},
        32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_d3", ad[3], 32'd0);
    tick();
    rst = 1'b0;
    fv0 = fv_count;
    repeat (15) tick();
    chk("t5_late_done_no_fv", fv_count, fv0);
    chk("t5_busy_after", {31'd0, busy}, 32'd0);
    chk("t5_freq_after", {28'd0, freq_out}, 32'd0);

    // Spurious ana_done while idle
    jobs.push_back('{3, 4'd13, 1'b1, 32'hE000_0001});
    exp_q.push_back(4'd13);
    send_cycle(32'hE000_0001, 8'h61);
    fft_valid = 1'b0;
    wait_idle("t6_idle", 40);
    repeat (2) tick();
    chk("t6_freq_before", {28'd0, freq_out}, 32'd13);
    fv0 = fv_count;
    spur_freq = 4'd2;
    spur_cnt++;
    repeat (6) tick();
    chk("t6_freq_unchanged", {28'd0, freq_out}, 32'd13);
    chk("t6_no_fv", fv_count, fv0);

    repeat (5) tick();
    chk("exp_queue_empty", exp_q.size(), 32'd0);
    chk("job_queue_empty", jobs.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_frame_scheduler.md
# fft_frame_scheduler

Frame scheduler between the FFT core and the `analyze` peak-frequency block. It buffers up to DEPTH 16-bin FFT frames arriving on `fft_valid` and issues them to the analyzer one at a time with a start/done handshake. It returns each frame's dominant-bin index as `freq_out`/`freq_valid`. It also reports dropped frames and analyzer timeouts.

## Interface

- DEPTH, 2: frame buffer entries (power of two, 2..4).
- TIMEOUT, 31: maximum WAIT cycles before abandoning a frame (≥16).
- clk input 1: system clock, all logic on rising edge.
- rst input 1: asynchronous, active-high reset.
- fft_valid input 1: one-cycle strobe; fft_d0..fft_d15 hold a frame this cycle.
- fft_d0 … fft_d15 input 32 each: bin data, {real[31:16], imag[15:0]}, passed through unmodified.
- ana_valid output 1: one-cycle start pulse to the analyzer's fft_valid.
- ana_d0 … ana_d15 output 32 each: head-of-buffer frame, driven to the analyzer's fft_d*.
- ana_done input 1: analyzer completion pulse.
- ana_freq input 4: analyzer result, valid while ana_done=1.
- freq_out output 4: last captured result, registered.
- freq_valid output 1: one-cycle pulse when freq_out updates.
- busy output 1: high when state≠IDLE or the buffer is non-empty.
- overflow output 1: sticky; a frame was dropped.
- timeout output 1: sticky; the analyzer failed to finish within TIMEOUT cycles.
- drop_cnt output 8: count of dropped frames, saturating at 255.
- flag_clr input 1: synchronous clear of overflow, timeout and drop_cnt.

## Operation

- Buffer: circular FIFO of DEPTH×16×32-bit entries, with write pointer, read pointer and count (0..DEPTH).
  - Push on fft_valid=1 if it is accepted.
  - Pop happens in the ISSUE state.
- Push acceptance: a push is accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
  - Otherwise the frame is dropped, overflow is set, and drop_cnt increments unless it is at 255.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if count>0, go to ISSUE. ana_done is ignored.
  - ISSUE: ana_valid=1 and ana_d* = head entry. Pop the head, clear the timer, go to WAIT. ana_done is ignored.
  - WAIT: the timer increments each cycle.
  - WAIT, ana_done=1: freq_out←ana_freq, freq_valid=1 next cycle, go to IDLE.
  - WAIT, timer==TIMEOUT-1 with no ana_done: set timeout, go to IDLE, no freq_valid.
  - WAIT: ana_done takes priority when it coincides with timer expiry.
- ana_d* always shows the head entry, whether or not the buffer is empty. Its value is only meaningful while ana_valid=1.
- flag_clr clears the sticky flags and drop_cnt. If a drop happens in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- Reset values: state IDLE, pointers and count 0, buffer contents 0, timer 0. All outputs 0, so ana_d*=0.
- Reset mid-operation discards buffered frames and any in-flight analysis. A late ana_done after reset is ignored, because it arrives in IDLE.

## Timing

- Frame sampled at edge E0, buffer empty, state IDLE:
  - ISSUE after edge E1.
  - ana_valid high from E1 to E2.
  - WAIT from E2.
- ana_done sampled at edge Ek: freq_out and freq_valid are valid after Ek for exactly one cycle. The state is IDLE after Ek.
- Back-to-back with a non-empty buffer: the next ana_valid rises at Ek+1. That is one IDLE cycle plus one ISSUE cycle per frame of overhead.
- fft_valid may be asserted every cycle. Acceptance follows the buffer rule above.
- Timeout: with no ana_done, IDLE is reached TIMEOUT cycles after WAIT is entered.
- No combinational path from fft_* to ana_*. From ana_done to freq_out/freq_valid there is a one-register delay.

## Test plan

- Single frame, analyzer model responds with ana_done and ana_freq=5 after 14 cycles:
  - ana_valid for one cycle, one cycle after fft_valid.
  - ana_d3 equals the input fft_d3 (e.g. 32'h0040_FFC0).
  - freq_out=5 with a single freq_valid pulse.
  - overflow=0.
- Three fft_valid pulses on consecutive cycles, DEPTH=2:
  - All three are accepted, because the first is popped in ISSUE while the third arrives.
  - Three freq_valid pulses with results 2, 7, 15, in order.
  - drop_cnt=0.
- Fourth frame arriving during WAIT while count==2:
  - The frame is dropped; overflow=1, drop_cnt=1.
  - Then pulse flag_clr: overflow=0, drop_cnt=0.
- Analyzer never responds, TIMEOUT=31:
  - timeout=1 exactly 31 cycles after entering WAIT.
  - No freq_valid.
  - The next buffered frame is issued 2 cycles later.
- Assert rst mid-WAIT with 1 frame buffered:
  - All outputs are 0 and busy=0.
  - A subsequent ana_done produces no freq_valid.
- Spurious ana_done in IDLE: freq_out is unchanged and freq_valid stays 0.
